// File: rtl/mult_share_arb.sv
// Round-robin arbiter time-sharing one 2-stage signed fixed-point multiplier among N_REQ
// requesters; each rounded product returns tagged with the index of the requester that issued it.
module mult_share_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_a,
    input  logic [N_REQ*WIDTH-1:0] i_b,
    input  logic                   i_clr,
    output logic [N_REQ-1:0]       o_gnt,
    output logic                   o_valid,
    output logic [ID_W-1:0]        o_id,
    output logic [WIDTH-1:0]       o_res,
    output logic                   o_busy
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]    id1_q, id1_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;

    // Two passes emulate the circular scan p..N_REQ-1, then 0..p-1.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!gnt_any && i_req[j] && (j >= 32'(ptr_q))) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_id  = ID_W'(j);
            end
        end
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!gnt_any && i_req[j] && (j < 32'(ptr_q))) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_id  = ID_W'(j);
            end
        end
        if (!rst_n || i_clr) begin
            gnt     = '0;
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (gnt[j]) begin
                a_sel = i_a[j*WIDTH +: WIDTH];
                b_sel = i_b[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_clr) begin
            ptr_d = '0;
        end else if (gnt_any) begin
            ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end

        v1_d  = gnt_any;
        a_d   = gnt_any ? a_sel : a_q;
        b_d   = gnt_any ? b_sel : b_q;
        id1_d = gnt_any ? gnt_id : id1_q;
    end

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod    = a_ext * b_ext;
        valid_d = v1_q && !i_clr;
        id_d    = v1_q ? id1_q : id_q;
        res_d   = v1_q ? prod[FRAC+WIDTH-1:FRAC] + {{(WIDTH-1){1'b0}}, prod[FRAC-1]} : res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            v1_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id1_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            res_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            v1_q    <= v1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id1_q   <= id1_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            res_q   <= res_d;
        end
    end

    assign o_gnt   = gnt;
    assign o_valid = valid_q;
    assign o_id    = id_q;
    assign o_res   = res_q;
    assign o_busy  = v1_q | valid_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: vector table for arbitration/arithmetic plus hand-written
// flush and asynchronous-reset sequences.
module tb_mult_share_arb;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 24;
    localparam int unsigned FRAC  = 16;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned NVEC  = 18;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*WIDTH-1:0] i_a;
    logic [N_REQ*WIDTH-1:0] i_b;
    logic                   i_clr;
    logic [N_REQ-1:0]       o_gnt;
    logic                   o_valid;
    logic [ID_W-1:0]        o_id;
    logic [WIDTH-1:0]       o_res;
    logic                   o_busy;

    mult_share_arb #(
        .N_REQ(N_REQ),
        .WIDTH(WIDTH),
        .FRAC (FRAC),
        .ID_W (ID_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (i_req),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_clr  (i_clr),
        .o_gnt  (o_gnt),
        .o_valid(o_valid),
        .o_id   (o_id),
        .o_res  (o_res),
        .o_busy (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [23:0] a;
        logic [23:0] b;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic [23:0] res;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_chk;
    int   n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Requester lanes other than the expected winner carry decoy operands.
    task automatic drive(input logic [3:0] req, input logic [3:0] lane,
                         input logic [23:0] a, input logic [23:0] b);
        i_req = req;
        for (int k = 0; k < 4; k++) begin
            i_a[k*WIDTH +: WIDTH] = lane[k] ? a : 24'h123456;
            i_b[k*WIDTH +: WIDTH] = lane[k] ? b : 24'h010000;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        // Round-robin with all four requesting; 1.0 * b = b.
        vecs[0]  = '{4'b1111, 24'h010000, 24'h000100, 4'b0001, 2'd0, 24'h000100};
        vecs[1]  = '{4'b1111, 24'h010000, 24'h000200, 4'b0010, 2'd1, 24'h000200};
        vecs[2]  = '{4'b1111, 24'h010000, 24'h000300, 4'b0100, 2'd2, 24'h000300};
        vecs[3]  = '{4'b1111, 24'h010000, 24'h000400, 4'b1000, 2'd3, 24'h000400};
        vecs[4]  = '{4'b1111, 24'h010000, 24'h000500, 4'b0001, 2'd0, 24'h000500};
        vecs[5]  = '{4'b1111, 24'h010000, 24'h000600, 4'b0010, 2'd1, 24'h000600};
        vecs[6]  = '{4'b1111, 24'h010000, 24'h000700, 4'b0100, 2'd2, 24'h000700};
        vecs[7]  = '{4'b1111, 24'h010000, 24'h000800, 4'b1000, 2'd3, 24'h000800};
        // Arithmetic, single requester held every cycle.
        vecs[8]  = '{4'b0001, 24'h018000, 24'h020000, 4'b0001, 2'd0, 24'h030000};
        vecs[9]  = '{4'b0001, 24'h000001, 24'h008000, 4'b0001, 2'd0, 24'h000001};
        vecs[10] = '{4'b0001, 24'hFF0000, 24'h008000, 4'b0001, 2'd0, 24'hFF8000};
        vecs[11] = '{4'b0001, 24'hFFFFFF, 24'h008000, 4'b0001, 2'd0, 24'h000000};
        vecs[12] = '{4'b0001, 24'h7FFFFF, 24'h020000, 4'b0001, 2'd0, 24'hFFFFFE};
        vecs[13] = '{4'b0000, 24'h000000, 24'h000000, 4'b0000, 2'd0, 24'h000000};
        // Pointer stickiness: pointer is 1 here.
        vecs[14] = '{4'b0100, 24'h020000, 24'h000300, 4'b0100, 2'd2, 24'h000600};
        vecs[15] = '{4'b1001, 24'hFE0000, 24'h030000, 4'b1000, 2'd3, 24'hFA0000};
        vecs[16] = '{4'b1001, 24'h008000, 24'h008000, 4'b0001, 2'd0, 24'h004000};
        vecs[17] = '{4'b0011, 24'h000003, 24'h008000, 4'b0010, 2'd1, 24'h000002};

        rst_n = 1'b0;
        i_clr = 1'b0;
        drive(4'b1111, 4'b1111, 24'h010000, 24'h010000);
        #2;
        chk("reset_gnt", 32'(o_gnt), 32'h0);
        chk("reset_valid", 32'(o_valid), 32'h0);
        chk("reset_id", 32'(o_id), 32'h0);
        chk("reset_res", 32'(o_res), 32'h0);
        chk("reset_busy", 32'(o_busy), 32'h0);
        next_cycle();
        rst_n = 1'b1;

        for (int r = 0; r < int'(NVEC) + 2; r++) begin
            if (r < int'(NVEC)) drive(vecs[r].req, vecs[r].gnt, vecs[r].a, vecs[r].b);
            else                drive(4'b0000, 4'b0000, 24'h0, 24'h0);
            #1;
            if (r < int'(NVEC)) chk($sformatf("gnt[%0d]", r), 32'(o_gnt), 32'(vecs[r].gnt));
            if (r >= 2 && vecs[r-2].gnt != 4'b0000) begin
                chk($sformatf("valid[%0d]", r - 2), 32'(o_valid), 32'h1);
                chk($sformatf("id[%0d]", r - 2), 32'(o_id), 32'(vecs[r-2].id));
                chk($sformatf("res[%0d]", r - 2), 32'(o_res), 32'(vecs[r-2].res));
            end else begin
                chk($sformatf("novalid[%0d]", r), 32'(o_valid), 32'h0);
            end
            next_cycle();
        end
        chk("idle_busy", 32'(o_busy), 32'h0);

        // Flush: pointer is 2; grant 0 then 1, then clear with everyone requesting.
        drive(4'b0001, 4'b0001, 24'h010000, 24'h000111);
        #1 chk("fl_gnt0", 32'(o_gnt), 32'h1);
        next_cycle();
        drive(4'b0010, 4'b0010, 24'h010000, 24'h000222);
        #1 chk("fl_gnt1", 32'(o_gnt), 32'h2);
        next_cycle();
        i_clr = 1'b1;
        drive(4'b1111, 4'b1111, 24'h010000, 24'h000333);
        #1 chk("fl_clr_gnt", 32'(o_gnt), 32'h0);
        chk("fl_first_valid", 32'(o_valid), 32'h1);
        chk("fl_first_res", 32'(o_res), 32'h000111);
        next_cycle();
        i_clr = 1'b0;
        drive(4'b0000, 4'b0000, 24'h0, 24'h0);
        #1 chk("fl_valid_a", 32'(o_valid), 32'h0);
        chk("fl_busy", 32'(o_busy), 32'h0);
        next_cycle();
        drive(4'b1111, 4'b1111, 24'h010000, 24'h000444);
        #1 chk("fl_valid_b", 32'(o_valid), 32'h0);
        chk("fl_ptr0_gnt", 32'(o_gnt), 32'h1);
        next_cycle();

        // Asynchronous reset mid-operation: pointer is 1 after the grant to 0.
        drive(4'b0100, 4'b0100, 24'h010000, 24'h000555);
        #1 chk("rs_gnt2", 32'(o_gnt), 32'h4);
        next_cycle();
        drive(4'b1000, 4'b1000, 24'h010000, 24'h000666);
        #1 chk("rs_gnt3", 32'(o_gnt), 32'h8);
        next_cycle();
        chk("rs_pre_busy", 32'(o_busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rs_valid", 32'(o_valid), 32'h0);
        chk("rs_res", 32'(o_res), 32'h0);
        chk("rs_busy", 32'(o_busy), 32'h0);
        chk("rs_gnt", 32'(o_gnt), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 24'h0, 24'h0);
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("rs_novalid[%0d]", c), 32'(o_valid), 32'h0);
            next_cycle();
        end
        drive(4'b1111, 4'b1111, 24'h010000, 24'h000777);
        #1 chk("rs_ptr0_gnt", 32'(o_gnt), 32'h1);
        next_cycle();
        drive(4'b0000, 4'b0000, 24'h0, 24'h0);
        next_cycle();
        chk("rs_after_valid", 32'(o_valid), 32'h1);
        chk("rs_after_res", 32'(o_res), 32'h000777);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
